piece_motion_engine: RTL and testbench



---
 rtl/piece_motion_engine.sv | 226 ++++++++++++++++++++++
 tb/tb_piece_motion_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_motion_engine.sv
// ============================================================================
//  Module   : piece_motion_engine
//  Function : Active-piece coordinate bank; validates and commits spawn,
//             shift, drop and rotate moves against bounds and board occupancy.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module piece_motion_engine #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int XW      = 5,
    parameter int YW      = 6,
    parameter int NCELLS  = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 cmd_valid,
    input  logic [2:0]           cmd,
    output logic                 cmd_ready,
    input  logic [NCELLS*XW-1:0] spawn_x,
    input  logic [NCELLS*YW-1:0] spawn_y,
    output logic                 occ_req,
    output logic [XW-1:0]        occ_x,
    output logic [YW-1:0]        occ_y,
    input  logic                 occ_hit,
    output logic [NCELLS*XW-1:0] cell_x,
    output logic [NCELLS*YW-1:0] cell_y,
    output logic                 piece_valid,
    output logic                 done,
    output logic                 blocked,
    output logic                 landed,
    output logic                 game_over
);

    localparam int c_iw = (NCELLS > 1) ? $clog2(NCELLS) : 1;
    localparam int c_xs = XW + 1;
    localparam int c_ys = YW + 1;

    localparam logic [XW:0]     c_board_w = c_xs'(BOARD_W);
    localparam logic [YW:0]     c_board_h = c_ys'(BOARD_H);
    localparam logic [c_iw-1:0] c_last    = c_iw'(NCELLS - 1);

    localparam logic [2:0] c_cmd_spawn  = 3'd1;
    localparam logic [2:0] c_cmd_left   = 3'd2;
    localparam logic [2:0] c_cmd_right  = 3'd3;
    localparam logic [2:0] c_cmd_down   = 3'd4;
    localparam logic [2:0] c_cmd_rotate = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CHECK  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [NCELLS*XW-1:0] r_cell_x;
    logic [NCELLS*YW-1:0] r_cell_y;
    logic                 r_piece_valid;
    logic [XW:0]          r_cand_x [NCELLS];
    logic [YW:0]          r_cand_y [NCELLS];
    logic [c_iw-1:0]      r_idx;
    logic [2:0]           r_cmd;
    logic                 r_blocked;

    logic [XW:0] w_cand_x [NCELLS];
    logic [YW:0] w_cand_y [NCELLS];
    int          w_nx     [NCELLS];
    int          w_ny     [NCELLS];
    int          w_px;
    int          w_py;
    logic        w_move;
    logic        w_accept;
    logic [XW:0] w_cx;
    logic [YW:0] w_cy;
    logic        w_oob;
    logic        w_hit;
    logic        w_last;

    assign w_move   = (cmd >= c_cmd_left) && (cmd <= c_cmd_rotate);
    assign w_accept = (r_state == S_IDLE) && cmd_valid;

    // Candidate set is formed from the committed piece while idle, so it can
    // be captured in the same edge that accepts the command.
    always_comb begin
        w_px = int'(r_cell_x[XW +: XW]);
        w_py = int'(r_cell_y[YW +: YW]);
        for (int i = 0; i < NCELLS; i++) begin
            w_nx[i] = int'(r_cell_x[i*XW +: XW]);
            w_ny[i] = int'(r_cell_y[i*YW +: YW]);
            case (cmd)
                c_cmd_spawn: begin
                    w_nx[i] = int'(spawn_x[i*XW +: XW]);
                    w_ny[i] = int'(spawn_y[i*YW +: YW]);
                end
                c_cmd_left:  w_nx[i] = int'(r_cell_x[i*XW +: XW]) - 1;
                c_cmd_right: w_nx[i] = int'(r_cell_x[i*XW +: XW]) + 1;
                c_cmd_down:  w_ny[i] = int'(r_cell_y[i*YW +: YW]) + 1;
                c_cmd_rotate: begin
                    if (i != 1) begin
                        w_nx[i] = w_px - (int'(r_cell_y[i*YW +: YW]) - w_py);
                        w_ny[i] = w_py + (int'(r_cell_x[i*XW +: XW]) - w_px);
                    end
                end
                default: ;
            endcase
            w_cand_x[i] = c_xs'(w_nx[i]);
            w_cand_y[i] = c_ys'(w_ny[i]);
        end
    end

    // A negative or too-large coordinate counts as a hit without a query.
    assign w_cx   = r_cand_x[r_idx];
    assign w_cy   = r_cand_y[r_idx];
    assign w_oob  = w_cx[XW] || ({1'b0, w_cx[XW-1:0]} >= c_board_w) ||
                    w_cy[YW] || ({1'b0, w_cy[YW-1:0]} >= c_board_h);
    assign w_hit  = w_oob || occ_hit;
    assign w_last = (r_idx == c_last);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        cmd_ready   = 1'b0;
        occ_req     = 1'b0;
        occ_x       = '0;
        occ_y       = '0;
        done        = 1'b0;
        blocked     = 1'b0;
        landed      = 1'b0;
        game_over   = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (w_move && !r_piece_valid) begin
                        w_state_nxt = S_FINISH;
                    end else if (w_move || (cmd == c_cmd_spawn)) begin
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_state_nxt = S_FINISH;
                    end
                end
            end
            S_CHECK: begin
                occ_req = !w_oob;
                occ_x   = w_cx[XW-1:0];
                occ_y   = w_cy[YW-1:0];
                if (w_hit || w_last) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                done        = 1'b1;
                blocked     = r_blocked;
                landed      = r_blocked && (r_cmd == c_cmd_down) && r_piece_valid;
                game_over   = r_blocked && (r_cmd == c_cmd_spawn);
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cell_x      <= '0;
            r_cell_y      <= '0;
            r_piece_valid <= 1'b0;
            r_idx         <= '0;
            r_cmd         <= '0;
            r_blocked     <= 1'b0;
            for (int i = 0; i < NCELLS; i++) begin
                r_cand_x[i] <= '0;
                r_cand_y[i] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cmd     <= cmd;
                        r_idx     <= '0;
                        r_blocked <= w_move && !r_piece_valid;
                        for (int i = 0; i < NCELLS; i++) begin
                            r_cand_x[i] <= w_cand_x[i];
                            r_cand_y[i] <= w_cand_y[i];
                        end
                    end
                end
                S_CHECK: begin
                    if (w_hit) begin
                        r_blocked <= 1'b1;
                        if (r_cmd == c_cmd_spawn) begin
                            r_piece_valid <= 1'b0;
                        end
                    end else if (w_last) begin
                        for (int i = 0; i < NCELLS; i++) begin
                            r_cell_x[i*XW +: XW] <= r_cand_x[i][XW-1:0];
                            r_cell_y[i*YW +: YW] <= r_cand_y[i][YW-1:0];
                        end
                        if (r_cmd == c_cmd_spawn) begin
                            r_piece_valid <= 1'b1;
                        end
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cell_x      = r_cell_x;
    assign cell_y      = r_cell_y;
    assign piece_valid = r_piece_valid;

endmodule

`default_nettype wire

// File: tb/tb_piece_motion_engine.sv
// ============================================================================
//  Module   : tb_piece_motion_engine
//  Function : Directed self-checking bench for piece_motion_engine.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_piece_motion_engine;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic [2:0]  cmd;
    logic        cmd_ready;
    logic [19:0] spawn_x;
    logic [23:0] spawn_y;
    logic        occ_req;
    logic [4:0]  occ_x;
    logic [5:0]  occ_y;
    logic        occ_hit;
    logic [19:0] cell_x;
    logic [23:0] cell_y;
    logic        piece_valid;
    logic        done;
    logic        blocked;
    logic        landed;
    logic        game_over;

    logic        hit_en;
    logic [4:0]  hit_x;
    logic [5:0]  hit_y;

    int errors;
    int checks;
    int lat;
    int nreq;
    logic        got_done;
    logic        d_blocked, d_landed, d_go, d_pv;
    logic [19:0] d_cx;
    logic [23:0] d_cy;

    piece_motion_engine dut (
        .Clk         (clk),
        .Reset       (rst),
        .cmd_valid   (cmd_valid),
        .cmd         (cmd),
        .cmd_ready   (cmd_ready),
        .spawn_x     (spawn_x),
        .spawn_y     (spawn_y),
        .occ_req     (occ_req),
        .occ_x       (occ_x),
        .occ_y       (occ_y),
        .occ_hit     (occ_hit),
        .cell_x      (cell_x),
        .cell_y      (cell_y),
        .piece_valid (piece_valid),
        .done        (done),
        .blocked     (blocked),
        .landed      (landed),
        .game_over   (game_over)
    );

    // Occupancy memory model: a single injectable occupied cell.
    assign occ_hit = hit_en && occ_req && (occ_x == hit_x) && (occ_y == hit_y);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] pk_x(input int a, input int b, input int c, input int d);
        logic [19:0] v;
        v = {5'(d), 5'(c), 5'(b), 5'(a)};
        return v;
    endfunction

    function automatic logic [23:0] pk_y(input int a, input int b, input int c, input int d);
        logic [23:0] v;
        v = {6'(d), 6'(c), 6'(b), 6'(a)};
        return v;
    endfunction

    // Issue one command, then watch up to 20 cycles for done.
    task automatic do_cmd(input logic [2:0] c);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = c;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd       = 3'd0;
        lat       = 0;
        nreq      = 0;
        got_done  = 1'b0;
        for (int k = 1; k <= 20 && !got_done; k++) begin
            @(negedge clk);
            if (occ_req) nreq++;
            if (done) begin
                got_done  = 1'b1;
                lat       = k;
                d_blocked = blocked;
                d_landed  = landed;
                d_go      = game_over;
                d_pv      = piece_valid;
                d_cx      = cell_x;
                d_cy      = cell_y;
            end
        end
        chk("done_seen", 64'(got_done), 64'd1);
    endtask

    task automatic spawn(input logic [19:0] sx, input logic [23:0] sy);
        spawn_x = sx;
        spawn_y = sy;
        do_cmd(3'd1);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd       = 3'd0;
        spawn_x   = '0;
        spawn_y   = '0;
        hit_en    = 1'b0;
        hit_x     = '0;
        hit_y     = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(cmd_ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pv", 64'(piece_valid), 64'd0);
        chk("rst_cx", 64'(cell_x), 64'd0);
        chk("rst_cy", 64'(cell_y), 64'd0);
        chk("rst_occ", 64'(occ_req), 64'd0);

        // SPAWN horizontal T-ish piece, no occupancy
        spawn(pk_x(4, 5, 6, 5), pk_y(0, 0, 0, 1));
        chk("sp_lat", 64'(lat), 64'd5);
        chk("sp_nreq", 64'(nreq), 64'd4);
        chk("sp_blk", 64'(d_blocked), 64'd0);
        chk("sp_pv", 64'(d_pv), 64'd1);
        chk("sp_cx", 64'(d_cx), 64'(pk_x(4, 5, 6, 5)));
        chk("sp_cy", 64'(d_cy), 64'(pk_y(0, 0, 0, 1)));
        @(negedge clk);
        chk("sp_ready_after", 64'(cmd_ready), 64'd1);

        // LEFT at the wall: blocked on index 0 without a query
        spawn(pk_x(0, 1, 2, 1), pk_y(5, 5, 5, 6));
        do_cmd(3'd2);
        chk("left_lat", 64'(lat), 64'd2);
        chk("left_nreq", 64'(nreq), 64'd0);
        chk("left_blk", 64'(d_blocked), 64'd1);
        chk("left_landed", 64'(d_landed), 64'd0);
        chk("left_cx", 64'(d_cx), 64'(pk_x(0, 1, 2, 1)));

        // RIGHT from the same place succeeds
        do_cmd(3'd3);
        chk("right_lat", 64'(lat), 64'd5);
        chk("right_blk", 64'(d_blocked), 64'd0);
        chk("right_cx", 64'(d_cx), 64'(pk_x(1, 2, 3, 2)));
        chk("right_cy", 64'(d_cy), 64'(pk_y(5, 5, 5, 6)));

        // DOWN near the floor, index 2 occupied
        spawn(pk_x(3, 4, 5, 4), pk_y(18, 18, 18, 19));
        hit_en = 1'b1;
        hit_x  = 5'd5;
        hit_y  = 6'd19;
        do_cmd(3'd4);
        hit_en = 1'b0;
        chk("down_lat", 64'(lat), 64'd4);
        chk("down_nreq", 64'(nreq), 64'd3);
        chk("down_blk", 64'(d_blocked), 64'd1);
        chk("down_landed", 64'(d_landed), 64'd1);
        chk("down_pv", 64'(d_pv), 64'd1);
        chk("down_cy", 64'(d_cy), 64'(pk_y(18, 18, 18, 19)));

        // ROTATE horizontal I about (4,4)
        spawn(pk_x(3, 4, 5, 6), pk_y(4, 4, 4, 4));
        do_cmd(3'd5);
        chk("rot_lat", 64'(lat), 64'd5);
        chk("rot_blk", 64'(d_blocked), 64'd0);
        chk("rot_cx", 64'(d_cx), 64'(pk_x(4, 4, 4, 4)));
        chk("rot_cy", 64'(d_cy), 64'(pk_y(3, 4, 5, 6)));

        // NOP codes
        do_cmd(3'd6);
        chk("nop_lat", 64'(lat), 64'd1);
        chk("nop_blk", 64'(d_blocked), 64'd0);
        chk("nop_cx", 64'(d_cx), 64'(pk_x(4, 4, 4, 4)));

        // Reset while checking index 1 of a DOWN
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd       = 3'd4;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd       = 3'd0;
        @(negedge clk);
        chk("mid_idx0_done", 64'(done), 64'd0);
        @(negedge clk);
        chk("mid_idx1_req", 64'(occ_req), 64'd1);
        chk("mid_idx1_y", 64'(occ_y), 64'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_done", 64'(done), 64'd0);
        chk("mid_ready", 64'(cmd_ready), 64'd1);
        chk("mid_pv", 64'(piece_valid), 64'd0);
        chk("mid_cx", 64'(cell_x), 64'd0);
        chk("mid_cy", 64'(cell_y), 64'd0);
        chk("mid_occ", 64'(occ_req), 64'd0);
        @(negedge clk);
        chk("mid_done_after", 64'(done), 64'd0);

        // SPAWN onto an occupied cell at index 0
        spawn(pk_x(4, 5, 6, 5), pk_y(0, 0, 0, 1));
        chk("sp_ok_pv", 64'(d_pv), 64'd1);
        hit_en = 1'b1;
        hit_x  = 5'd7;
        hit_y  = 6'd2;
        spawn(pk_x(7, 8, 9, 8), pk_y(2, 2, 2, 3));
        hit_en = 1'b0;
        chk("go_lat", 64'(lat), 64'd2);
        chk("go_blk", 64'(d_blocked), 64'd1);
        chk("go_flag", 64'(d_go), 64'd1);
        chk("go_pv", 64'(d_pv), 64'd0);
        chk("go_cx", 64'(d_cx), 64'(pk_x(4, 5, 6, 5)));

        // DOWN with no active piece short-circuits
        do_cmd(3'd4);
        chk("nopiece_lat", 64'(lat), 64'd1);
        chk("nopiece_blk", 64'(d_blocked), 64'd1);
        chk("nopiece_nreq", 64'(nreq), 64'd0);
        chk("nopiece_go", 64'(d_go), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
